hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Generates the write enables and flush strobes for the pipeline registers (PC, IF/ID, ID/EX).
- Detects load-use and branch-operand hazards.
- Sequences the multi-cycle multiply/divide unit, stalling dependent HI/LO reads and back-to-back mult/div issues until the unit completes.
- Sits beside the ID stage and drives the `we` inputs of the enable-gated pipeline registers.

Parameters:
- MULT_CYCLES, 4, number of BUSY cycles for mult/multu (>=1).
- DIV_CYCLES, 32, number of BUSY cycles for div/divu (>=1).
- CNT_W, 16, width of the saturating stall performance counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- id_rs  input  5  rs field of the instruction in ID.
- id_rt  input  5  rt field of the instruction in ID.
- id_uses_rt  input  1  ID instruction reads rt as a source.
- id_branch  input  1  ID instruction is beq/bne; operands are compared in ID.
- id_branch_taken  input  1  branch comparison in ID resolved taken.
- id_md_start  input  1  ID instruction is mult/multu/div/divu.
- id_md_is_div  input  1  qualifies id_md_start: 1 = div, 0 = mult.
- id_uses_hilo  input  1  ID instruction is mfhi/mflo.
- ex_memread  input  1  EX instruction is a load.
- ex_regwrite  input  1  EX instruction writes the register file.
- ex_wa  input  5  EX destination register.
- we_pc  output  1  PC register write enable.
- we_ifid  output  1  IF/ID register write enable.
- flush_ifid  output  1  clear IF/ID to a nop on the next edge.
- flush_idex  output  1  clear ID/EX to a bubble on the next edge.
- md_go  output  1  one-cycle launch pulse to the mult/div datapath.
- md_busy  output  1  mult/div state is BUSY.
- md_done  output  1  registered; high for exactly the DONE cycle, commits HI/LO.
- stall_cnt  output  CNT_W  saturating count of stalled cycles.

Behaviour:
- Register $0 never creates a hazard. Every match below requires the compared field to be non-zero.
- rt_hit = id_uses_rt && (id_rt == ex_wa).
- load_use = ex_memread && ((id_rs == ex_wa) || rt_hit).
- br_dep = id_branch && ex_regwrite && ((id_rs == ex_wa) || (id_rt == ex_wa)).
- md_stall = (state != IDLE) && (id_uses_hilo || id_md_start).
- stall = load_use | br_dep | md_stall. All combinational, same cycle.
- When stall = 1:
  - we_pc = 0, we_ifid = 0, flush_idex = 1.
  - flush_ifid = 0: a stall overrides branch flush, and the branch re-evaluates next cycle.
- When stall = 0:
  - we_pc = 1, we_ifid = 1, flush_idex = 0.
  - flush_ifid = id_branch && id_branch_taken.
- md_go = id_md_start && (state == IDLE) && !stall. Combinational; accepted in the same cycle.
- Mult/div FSM, 2-bit state, counter wide enough for max(MULT_CYCLES, DIV_CYCLES):
  - IDLE: on md_go, load cnt = (id_md_is_div ? DIV_CYCLES : MULT_CYCLES) - 1 and go to BUSY. Otherwise stay in IDLE.
  - BUSY: md_busy = 1. If cnt == 0, go to DONE; otherwise decrement cnt.
  - DONE: md_done = 1 for one cycle, then go to IDLE unconditionally.
- Latency from the md_go edge: exactly N BUSY cycles, then 1 DONE cycle, then IDLE. N = MULT_CYCLES or DIV_CYCLES.
- mfhi/mflo or a new mult/div in ID stalls through BUSY and DONE, and proceeds in the first IDLE cycle. HI/LO is written at the end of DONE.
- Independent instructions flow unstalled while the FSM is BUSY.
- stall_cnt:
  - Increments on each rising edge where stall = 1.
  - Holds at 2^CNT_W - 1 (saturates, never wraps).
  - Cleared only by reset.
- Reset (rst_n = 0, asynchronous):
  - state = IDLE, cnt = 0, md_done = 0, stall_cnt = 0.
  - While rst_n = 0, outputs are forced: we_pc = 0, we_ifid = 0, flush_ifid = 1, flush_idex = 1, md_go = 0, md_busy = 0.
- Reset during BUSY or DONE aborts the operation. md_done is never pulsed for the aborted operation.
- Release is synchronous to the next clk edge, with no extra cycle.
- Simultaneous events:
  - load_use together with id_md_start in IDLE: no md_go; issue retries next cycle.
  - Taken branch in ID while the FSM is BUSY and the branch is independent: flush_ifid = 1 and the FSM is unaffected.

Test Plan:
- Reset: hold rst_n = 0 for 3 cycles mid-BUSY, then release -> state IDLE, md_done never pulses, stall_cnt = 0, we_pc = 1 on the first cycle after release.
- Load-use: ex_memread = 1, ex_wa = 5, id_rs = 5 -> exactly 1 cycle with we_pc = 0, we_ifid = 0, flush_idex = 1; stall_cnt = 1. Repeat with ex_wa = 0 -> no stall.
- Branch: id_branch = 1, id_branch_taken = 1, no dependency -> flush_ifid = 1, we_pc = 1. Add ex_regwrite = 1, ex_wa = id_rt = 9 -> flush_ifid = 0, stall = 1 that cycle.
- Mult: md_go at cycle 0 with MULT_CYCLES = 4 -> md_busy high cycles 1-4, md_done cycle 5, IDLE cycle 6. mfhi held in ID from cycle 1 -> stalled 5 cycles, released cycle 6.
- Div back-to-back: div, then div in the next instruction -> second div stalls 33 cycles; its md_go coincides with the first IDLE cycle after md_done.
- Saturation: with CNT_W = 4, hold a load-use stall 20 cycles -> stall_cnt reaches 15 and stays at 15.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// ID/EX hazard inputs and pipeline control outputs of the hazard controller.
interface hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rt;
  logic             id_branch;
  logic             id_branch_taken;
  logic             id_md_start;
  logic             id_md_is_div;
  logic             id_uses_hilo;
  logic             ex_memread;
  logic             ex_regwrite;
  logic [4:0]       ex_wa;
  logic             we_pc;
  logic             we_ifid;
  logic             flush_ifid;
  logic             flush_idex;
  logic             md_go;
  logic             md_busy;
  logic             md_done;
  logic [CNT_W-1:0] stall_cnt;

  modport slave (
    input  id_rs, id_rt, id_uses_rt, id_branch, id_branch_taken,
           id_md_start, id_md_is_div, id_uses_hilo,
           ex_memread, ex_regwrite, ex_wa,
    output we_pc, we_ifid, flush_ifid, flush_idex,
           md_go, md_busy, md_done, stall_cnt
  );

  modport master (
    output id_rs, id_rt, id_uses_rt, id_branch, id_branch_taken,
           id_md_start, id_md_is_div, id_uses_hilo,
           ex_memread, ex_regwrite, ex_wa,
    input  we_pc, we_ifid, flush_ifid, flush_idex,
           md_go, md_busy, md_done, stall_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use / branch-operand stalls, taken-branch
// flush, and sequencing of the multi-cycle mult/div unit.
//
// state  | meaning
// S_IDLE | mult/div unit free, may accept md_go
// S_BUSY | unit computing, r_cnt counts remaining BUSY cycles minus one
// S_DONE | single cycle, HI/LO committed at its end
module hazard_ctrl #(
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 32,
  parameter int CNT_W       = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  hazard_ctrl_if.slave  bus
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int MD_W    = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [MD_W-1:0] MULT_LOAD = MD_W'(MULT_CYCLES - 1);
  localparam logic [MD_W-1:0] DIV_LOAD  = MD_W'(DIV_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } md_state_t;

  md_state_t        r_state;
  logic [MD_W-1:0]  r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [CNT_W-1:0] r_stall_cnt;

  logic w_rs_hit, w_rt_match, w_rt_hit;
  logic w_load_use, w_br_dep, w_md_stall, w_stall, w_md_go;

  // $0 is hardwired, so a zero field never matches
  assign w_rs_hit   = (bus.id_rs != 5'd0) && (bus.id_rs == bus.ex_wa);
  assign w_rt_match = (bus.id_rt != 5'd0) && (bus.id_rt == bus.ex_wa);
  assign w_rt_hit   = bus.id_uses_rt && w_rt_match;

  assign w_load_use = bus.ex_memread && (w_rs_hit || w_rt_hit);
  // branches compare both operands in ID regardless of id_uses_rt
  assign w_br_dep   = bus.id_branch && bus.ex_regwrite && (w_rs_hit || w_rt_match);
  assign w_md_stall = (r_state != S_IDLE) && (bus.id_uses_hilo || bus.id_md_start);
  assign w_stall    = w_load_use || w_br_dep || w_md_stall;
  assign w_md_go    = bus.id_md_start && (r_state == S_IDLE) && !w_stall;

  // reset forces the pipeline frozen and both stage registers flushed
  assign bus.we_pc      = rst_n && !w_stall;
  assign bus.we_ifid    = rst_n && !w_stall;
  assign bus.flush_idex = !rst_n || w_stall;
  assign bus.flush_ifid = !rst_n || (!w_stall && bus.id_branch && bus.id_branch_taken);
  assign bus.md_go      = rst_n && w_md_go;
  assign bus.md_busy    = rst_n && r_busy;
  assign bus.md_done    = r_done;
  assign bus.stall_cnt  = r_stall_cnt;

  // mult/div sequencer with registered busy/done flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (w_md_go) begin
            r_cnt   <= bus.id_md_is_div ? DIV_LOAD : MULT_LOAD;
            r_state <= S_BUSY;
            r_busy  <= 1'b1;
          end
        end
        S_BUSY: begin
          if (r_cnt == '0) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_cnt <= r_cnt - MD_W'(1);
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  // saturating count of stalled cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios then randomized traffic, all
// checked each cycle against a cycle-budget model of the mult/div unit.
module tb_hazard_ctrl;

  localparam int MC = 4;
  localparam int DC = 32;
  localparam int CW = 4;
  localparam int SAT = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  hazard_ctrl_if #(.CNT_W(CW)) bus ();

  hazard_ctrl #(
    .MULT_CYCLES(MC),
    .DIV_CYCLES (DC),
    .CNT_W      (CW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  // cycles left before the mult/div unit is idle again (N busy + 1 done)
  int md_left = 0;
  int exp_cnt = 0;
  int stalls_seen = 0;
  int done_seen = 0;
  int s0, d0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    bus.id_rs = 5'd0;          bus.id_rt = 5'd0;
    bus.id_uses_rt = 1'b0;     bus.id_branch = 1'b0;
    bus.id_branch_taken = 1'b0;
    bus.id_md_start = 1'b0;    bus.id_md_is_div = 1'b0;
    bus.id_uses_hilo = 1'b0;
    bus.ex_memread = 1'b0;     bus.ex_regwrite = 1'b0;
    bus.ex_wa = 5'd0;
  endtask

  // inputs are already driven; check mid-cycle, then advance one clock
  task automatic step();
    bit rs_hit, rt_m, lu, bd, ms, st, go;
    bit e_we, e_fi, e_fx, e_go, e_busy, e_done;
    #4;
    if (!rst_n) begin
      md_left = 0;
      exp_cnt = 0;
    end
    rs_hit = (bus.ex_wa != 0) && (bus.id_rs == bus.ex_wa);
    rt_m   = (bus.ex_wa != 0) && (bus.id_rt == bus.ex_wa);
    lu = bus.ex_memread && (rs_hit || (bus.id_uses_rt && rt_m));
    bd = bus.id_branch && bus.ex_regwrite && (rs_hit || rt_m);
    ms = (md_left > 0) && (bus.id_uses_hilo || bus.id_md_start);
    st = lu || bd || ms;
    go = bus.id_md_start && (md_left == 0) && !st;
    if (rst_n) begin
      e_we = !st; e_fx = st; e_fi = !st && bus.id_branch && bus.id_branch_taken;
      e_go = go;  e_busy = (md_left > 1); e_done = (md_left == 1);
    end else begin
      e_we = 0; e_fx = 1; e_fi = 1; e_go = 0; e_busy = 0; e_done = 0;
    end
    chk("we_pc",      32'(bus.we_pc),      32'(e_we));
    chk("we_ifid",    32'(bus.we_ifid),    32'(e_we));
    chk("flush_idex", 32'(bus.flush_idex), 32'(e_fx));
    chk("flush_ifid", 32'(bus.flush_ifid), 32'(e_fi));
    chk("md_go",      32'(bus.md_go),      32'(e_go));
    chk("md_busy",    32'(bus.md_busy),    32'(e_busy));
    chk("md_done",    32'(bus.md_done),    32'(e_done));
    chk("stall_cnt",  32'(bus.stall_cnt),  32'(exp_cnt));
    if (bus.we_pc === 1'b0) stalls_seen++;
    if (bus.md_done === 1'b1) done_seen++;
    @(posedge clk);
    if (rst_n) begin
      if (md_left > 0) md_left--;
      else if (go) md_left = (bus.id_md_is_div ? DC : MC) + 1;
      if (st && exp_cnt < SAT) exp_cnt++;
    end
    #1;
  endtask

  initial begin
    clr();
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    step();

    // load-use on rs: single stall cycle
    bus.ex_memread = 1'b1; bus.ex_wa = 5'd5; bus.id_rs = 5'd5;
    s0 = stalls_seen;
    step();
    clr();
    step();
    chk("lu_stall_cycles", 32'(stalls_seen - s0), 32'd1);
    chk("lu_stall_cnt", 32'(bus.stall_cnt), 32'd1);
    // $0 never hazards
    bus.ex_memread = 1'b1; bus.ex_wa = 5'd0; bus.id_rs = 5'd0; bus.id_rt = 5'd0;
    bus.id_uses_rt = 1'b1;
    step();
    clr();

    // taken branch, independent, then dependent on rt
    bus.id_branch = 1'b1; bus.id_branch_taken = 1'b1; bus.id_rs = 5'd3; bus.id_rt = 5'd9;
    step();
    bus.ex_regwrite = 1'b1; bus.ex_wa = 5'd9;
    step();
    clr();
    step();

    // mult then mfhi held in ID
    bus.id_md_start = 1'b1; bus.id_md_is_div = 1'b0;
    step();
    clr();
    bus.id_uses_hilo = 1'b1;
    s0 = stalls_seen; d0 = done_seen;
    repeat (6) step();
    chk("mfhi_stall_cycles", 32'(stalls_seen - s0), 32'd5);
    chk("mult_done_pulses",  32'(done_seen - d0),   32'd1);
    clr();
    step();

    // independent taken branch while a mult is busy
    bus.id_md_start = 1'b1;
    step();
    clr();
    bus.id_branch = 1'b1; bus.id_branch_taken = 1'b1; bus.id_rs = 5'd1;
    repeat (2) step();
    clr();
    repeat (5) step();

    // back-to-back div
    bus.id_md_start = 1'b1; bus.id_md_is_div = 1'b1;
    step();
    s0 = stalls_seen;
    repeat (34) step();
    chk("div_b2b_stall_cycles", 32'(stalls_seen - s0), 32'd33);
    clr();
    repeat (3) step();

    // reset mid-BUSY aborts the second div
    d0 = done_seen;
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    chk("post_rst_cnt", 32'(bus.stall_cnt), 32'd0);
    repeat (40) step();
    chk("abort_no_done", 32'(done_seen - d0), 32'd0);

    // saturation of the stall counter
    bus.ex_memread = 1'b1; bus.ex_wa = 5'd7; bus.id_rt = 5'd7; bus.id_uses_rt = 1'b1;
    repeat (20) step();
    chk("sat_cnt", 32'(bus.stall_cnt), 32'(SAT));
    clr();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;

    // randomized traffic with occasional async reset
    for (int i = 0; i < 600; i++) begin
      rst_n = ($urandom_range(0, 80) != 0);
      bus.id_rs = 5'($urandom_range(0, 3));
      bus.id_rt = 5'($urandom_range(0, 3));
      bus.ex_wa = 5'($urandom_range(0, 3));
      bus.id_uses_rt = 1'($urandom_range(0, 1));
      bus.id_branch = ($urandom_range(0, 3) == 0);
      bus.id_branch_taken = 1'($urandom_range(0, 1));
      bus.id_md_start = ($urandom_range(0, 5) == 0);
      bus.id_md_is_div = ($urandom_range(0, 3) == 0);
      bus.id_uses_hilo = ($urandom_range(0, 5) == 0);
      bus.ex_memread = ($urandom_range(0, 3) == 0);
      bus.ex_regwrite = 1'($urandom_range(0, 1));
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
